// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: consumes 5-byte command frames from the UART receive path,
// executes a register write/read or start strobe, and issues one 4-byte reply
// to the transmit bridge. Replies are spaced by at least TX_GAP_CYCLES and one
// frame arriving while busy is held in a pending buffer.
// Build option: define CMD_CHECKSUM_EN to enable checksum validation (E2).
module uart_cmd_decoder #(
    parameter int         TX_GAP_CYCLES = 9000,
    parameter logic [7:0] HDR_BYTE      = 8'hAA,
    parameter logic [7:0] RSP_BYTE      = 8'h55
) (
    input  logic        clk_25m,
    input  logic        rst,
    input  logic        RX_rdy,
    input  logic [7:0]  DataRX_1,
    input  logic [7:0]  DataRX_2,
    input  logic [7:0]  DataRX_3,
    input  logic [7:0]  DataRX_4,
    input  logic [7:0]  DataRX_5,
    output logic        EnTxData,
    output logic [7:0]  DataTX_1,
    output logic [7:0]  DataTX_2,
    output logic [7:0]  DataTX_3,
    output logic [7:0]  DataTX_4,
    output logic        reg_wr,
    output logic        reg_rd,
    output logic [3:0]  reg_addr,
    output logic [15:0] reg_wdata,
    input  logic [15:0] reg_rdata,
    output logic        start_pulse,
    output logic        busy,
    output logic [7:0]  ovf_cnt
);

    localparam int GAP_W = (TX_GAP_CYCLES > 2) ? $clog2(TX_GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TX_GAP_CYCLES - 1);

    localparam logic [7:0] ST_WR  = 8'h00;
    localparam logic [7:0] ST_RD  = 8'h01;
    localparam logic [7:0] ST_GO  = 8'h03;
    localparam logic [7:0] ST_HDR = 8'hE1;
    localparam logic [7:0] ST_CKS = 8'hE2;
    localparam logic [7:0] ST_CMD = 8'hE3;

    typedef enum logic [2:0] {IDLE, CHECK, EXEC, CAPT, RESP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               rx_rdy_q;
    logic               rx_edge;
    logic [39:0]        new_frame;
    logic [39:0]        frame;
    logic [39:0]        pend;
    logic               pend_vld;
    logic [7:0]         status;
    logic [15:0]        rsp_data;
    logic [GAP_W-1:0]   gap_cnt;
    logic               cks_ok;

    // Status precedence: header, then checksum, then command legality.
    function automatic logic [7:0] calc_status(input logic [7:0] hdr,
                                               input logic [3:0] cmd,
                                               input logic       sum_ok);
        logic [7:0] st;
        if (hdr != HDR_BYTE)  st = ST_HDR;
        else if (!sum_ok)     st = ST_CKS;
        else if (cmd == 4'h1) st = ST_WR;
        else if (cmd == 4'h2) st = ST_RD;
        else if (cmd == 4'h3) st = ST_GO;
        else                  st = ST_CMD;
        return st;
    endfunction

    // Dropped-frame counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign new_frame = {DataRX_1, DataRX_2, DataRX_3, DataRX_4, DataRX_5};
    assign rx_edge   = RX_rdy & ~rx_rdy_q;
    assign reg_addr  = frame[27:24];
    assign reg_wdata = frame[23:8];
    assign busy      = (state != IDLE) || pend_vld;

`ifdef CMD_CHECKSUM_EN
    logic [7:0] sum;
    assign sum    = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    assign cks_ok = (frame[7:0] == sum);
`else
    logic unused_cks;
    assign unused_cks = ^frame[7:0];
    assign cks_ok     = 1'b1;
`endif

    // RX_rdy history for rising-edge detection.
    always_ff @(posedge clk_25m) begin
        if (rst) rx_rdy_q <= 1'b0;
        else     rx_rdy_q <= RX_rdy;
    end

    // FSM state register.
    always_ff @(posedge clk_25m) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state: fixed walk through check/exec/capture, reply waits on the gap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend_vld || rx_edge) state_nxt = CHECK;
            CHECK:   state_nxt = EXEC;
            EXEC:    state_nxt = CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame intake: pending frame wins in IDLE; a simultaneous edge refills the buffer.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            frame    <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            ovf_cnt  <= '0;
        end else if (state == IDLE) begin
            if (pend_vld) begin
                frame    <= pend;
                pend_vld <= rx_edge;
                if (rx_edge) pend <= new_frame;
            end else if (rx_edge) begin
                frame <= new_frame;
            end
        end else if (rx_edge) begin
            if (!pend_vld) begin
                pend     <= new_frame;
                pend_vld <= 1'b1;
            end else begin
                ovf_cnt <= sat_inc(ovf_cnt);
            end
        end
    end

    // Execution, reply capture, reply launch and inter-reply gap timing.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            status      <= '0;
            rsp_data    <= '0;
            gap_cnt     <= '0;
            reg_wr      <= 1'b0;
            reg_rd      <= 1'b0;
            start_pulse <= 1'b0;
            EnTxData    <= 1'b0;
            DataTX_1    <= '0;
            DataTX_2    <= '0;
            DataTX_3    <= '0;
            DataTX_4    <= '0;
        end else begin
            reg_wr      <= 1'b0;
            reg_rd      <= 1'b0;
            start_pulse <= 1'b0;
            EnTxData    <= 1'b0;
            if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
            case (state)
                CHECK: status <= calc_status(frame[39:32], frame[31:28], cks_ok);
                EXEC: begin
                    reg_wr      <= (status == ST_WR);
                    reg_rd      <= (status == ST_RD);
                    start_pulse <= (status == ST_GO);
                end
                CAPT: begin
                    if (status == ST_RD)      rsp_data <= reg_rdata;
                    else if (status == ST_WR) rsp_data <= frame[23:8];
                    else                      rsp_data <= '0;
                end
                RESP: begin
                    if (gap_cnt == '0) begin
                        DataTX_1 <= RSP_BYTE;
                        DataTX_2 <= status;
                        DataTX_3 <= rsp_data[15:8];
                        DataTX_4 <= rsp_data[7:0];
                        EnTxData <= 1'b1;
                        gap_cnt  <= GAP_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: table of single frames plus
// hand-written gap, overflow/saturation and reset sequences. Replies are
// checked through an expected-reply queue.
module tb_uart_cmd_decoder;

    localparam int G = 300;

    logic        clk_25m;
    logic        rst;
    logic        RX_rdy;
    logic [7:0]  DataRX_1, DataRX_2, DataRX_3, DataRX_4, DataRX_5;
    logic        EnTxData;
    logic [7:0]  DataTX_1, DataTX_2, DataTX_3, DataTX_4;
    logic        reg_wr, reg_rd, start_pulse, busy;
    logic [3:0]  reg_addr;
    logic [15:0] reg_wdata, reg_rdata;
    logic [7:0]  ovf_cnt;

    uart_cmd_decoder #(.TX_GAP_CYCLES(G), .HDR_BYTE(8'hAA), .RSP_BYTE(8'h55)) dut (
        .clk_25m(clk_25m), .rst(rst), .RX_rdy(RX_rdy),
        .DataRX_1(DataRX_1), .DataRX_2(DataRX_2), .DataRX_3(DataRX_3),
        .DataRX_4(DataRX_4), .DataRX_5(DataRX_5),
        .EnTxData(EnTxData), .DataTX_1(DataTX_1), .DataTX_2(DataTX_2),
        .DataTX_3(DataTX_3), .DataTX_4(DataTX_4),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .start_pulse(start_pulse), .busy(busy), .ovf_cnt(ovf_cnt)
    );

    typedef struct {
        logic [39:0] frame;
        logic [15:0] rdata;
        logic [2:0]  strobe;   // {start_pulse, reg_rd, reg_wr}
        logic [31:0] reply;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          npulse = 0;
    int          last_pulse = 0;
    int          prev_pulse = 0;
    logic        loose = 1'b0;

    initial clk_25m = 1'b0;
    always #5 clk_25m = ~clk_25m;

    always @(posedge clk_25m) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reply monitor: every EnTxData pulse is matched against the expected queue.
    always @(negedge clk_25m) begin
        if (EnTxData) begin
            npulse++;
            prev_pulse = last_pulse;
            last_pulse = cyc;
            if (loose) begin
                chk("reply_spam", 64'({DataTX_1, DataTX_2, DataTX_3, DataTX_4}), 64'h55003456);
            end else if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_reply: got %0h expected none",
                         {DataTX_1, DataTX_2, DataTX_3, DataTX_4});
            end else begin
                chk("reply_sb", 64'({DataTX_1, DataTX_2, DataTX_3, DataTX_4}), 64'(sbq.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk_25m);
        #1;
    endtask

    task automatic send_frame(input logic [39:0] f, output int t);
        {DataRX_1, DataRX_2, DataRX_3, DataRX_4, DataRX_5} = f;
        RX_rdy = 1'b1;
        @(posedge clk_25m);
        #1;
        t = cyc;
        RX_rdy = 1'b0;
    endtask

    task automatic wait_quiet;
        int n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        if (busy) chk("quiet_timeout", 64'(busy), 64'd0);
        repeat (G + 5) tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, 64'({EnTxData, DataTX_1, DataTX_2, DataTX_3, DataTX_4,
                             reg_wr, reg_rd, start_pulse, busy}), 64'd0);
        chk({tag, "_b"}, 64'({reg_addr, reg_wdata, ovf_cnt}), 64'd0);
    endtask

    localparam logic [39:0] WR_FRAME = 40'hAA12345646;

    initial begin
        int t, t2, n, n0;
        logic busy_all;

        vecs[0] = '{40'hAA12345646, 16'h0000, 3'b001, 32'h55003456};
        vecs[1] = '{40'hAA230000CD, 16'hBEEF, 3'b010, 32'h5501BEEF};
`ifdef CMD_CHECKSUM_EN
        vecs[2] = '{40'hAA12345647, 16'h0000, 3'b000, 32'h55E20000};
`else
        vecs[2] = '{40'hAA12345647, 16'h0000, 3'b001, 32'h55003456};
`endif
        vecs[3] = '{40'h001234569C, 16'h0000, 3'b000, 32'h55E10000};
        vecs[4] = '{40'hAA500000FA, 16'h0000, 3'b000, 32'h55E30000};
        vecs[5] = '{40'hAA310000DB, 16'h1234, 3'b100, 32'h55030000};

        rst = 1'b1;
        RX_rdy = 1'b0;
        {DataRX_1, DataRX_2, DataRX_3, DataRX_4, DataRX_5} = '0;
        reg_rdata = '0;
        repeat (3) tick();
        check_zero("reset_held");
        rst = 1'b0;
        tick();
        check_zero("reset_released");

        // Single-frame table: strobe timing, bus fields, reply timing and hold.
        for (int i = 0; i < 6; i++) begin
            wait_quiet();
            reg_rdata = vecs[i].rdata;
            sbq.push_back(vecs[i].reply);
            send_frame(vecs[i].frame, t);
            tick();
            chk("strobe_t1", 64'({start_pulse, reg_rd, reg_wr}), 64'd0);
            tick();
            chk("strobe_t2", 64'({start_pulse, reg_rd, reg_wr}), 64'(vecs[i].strobe));
            chk("bus_t2", 64'({reg_addr, reg_wdata}),
                64'({vecs[i].frame[27:24], vecs[i].frame[23:8]}));
            tick();
            chk("strobe_t3", 64'({start_pulse, reg_rd, reg_wr}), 64'd0);
            tick();
            chk("reply_t4", 64'({EnTxData, DataTX_1, DataTX_2, DataTX_3, DataTX_4}),
                64'({1'b1, vecs[i].reply}));
            tick();
            tick();
            chk("reply_hold", 64'({EnTxData, DataTX_1, DataTX_2, DataTX_3, DataTX_4}),
                64'({1'b0, vecs[i].reply}));
        end

        // Gap: second frame 100 cycles later replies exactly G cycles after the first.
        wait_quiet();
        n0 = npulse;
        sbq.push_back(32'h55003456);
        send_frame(WR_FRAME, t);
        repeat (99) tick();
        sbq.push_back(32'h55003456);
        send_frame(WR_FRAME, t2);
        chk("gap_first_lat", 64'(last_pulse - t), 64'd4);
        busy_all = 1'b1;
        n = 0;
        while (npulse < n0 + 2 && n < G + 50) begin
            if (!busy && !EnTxData) busy_all = 1'b0;
            tick();
            n++;
        end
        chk("gap_replies", 64'(npulse - n0), 64'd2);
        chk("gap_delta", 64'(last_pulse - prev_pulse), 64'(G));
        chk("gap_busy", 64'(busy_all), 64'd1);

        // Overflow: three frames inside one reply window, third is dropped.
        wait_quiet();
        n0 = npulse;
        sbq.push_back(32'h55003456);
        sbq.push_back(32'h5501BEEF);
        reg_rdata = 16'hBEEF;
        send_frame(WR_FRAME, t);
        tick();
        send_frame(40'hAA230000CD, t2);
        tick();
        send_frame(40'hAA500000FA, t2);
        tick();
        chk("ovf_one", 64'(ovf_cnt), 64'd1);
        chk("ovf_busy", 64'(busy), 64'd1);
        repeat (2 * G + 20) tick();
        chk("ovf_replies", 64'(npulse - n0), 64'd2);
        chk("ovf_queue", 64'(sbq.size()), 64'd0);

        // Saturation: far more than 255 drops must leave the counter at 255.
        wait_quiet();
        loose = 1'b1;
        for (int k = 0; k < 400; k++) begin
            send_frame(WR_FRAME, t);
            tick();
        end
        wait_quiet();
        loose = 1'b0;
        chk("ovf_sat", 64'(ovf_cnt), 64'd255);

        // Reset with a write strobe in flight: strobe never appears.
        send_frame(WR_FRAME, t);
        tick();
        rst = 1'b1;
        tick();
        check_zero("rst_exec");
        rst = 1'b0;

        // Reset while a reply waits on the gap: that reply is lost.
        wait_quiet();
        n0 = npulse;
        sbq.push_back(32'h55003456);
        send_frame(WR_FRAME, t);
        repeat (9) tick();
        send_frame(40'hAA230000CD, t2);
        repeat (8) tick();
        chk("rst_resp_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        check_zero("rst_resp");
        rst = 1'b0;
        repeat (G + 10) tick();
        chk("rst_no_reply", 64'(npulse - n0), 64'd1);

        // Fresh frame after reset replies at T+4 since the gap was cleared.
        sbq.push_back(32'h55003456);
        send_frame(WR_FRAME, t);
        repeat (4) tick();
        chk("fresh_entx", 64'(EnTxData), 64'd1);
        tick();
        chk("fresh_lat", 64'(last_pulse - t), 64'd4);
        repeat (5) tick();
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Command/response layer directly downstream of the UART receive path and upstream of its transmit path. Consumes each 5-byte frame (RX_rdy + DataRX_1..5), validates it, and executes a register write, register read or start strobe on a simple register bus. It then issues one 4-byte reply (DataTX_1..4 + EnTxData) to the transmit bridge. Enforces a minimum gap between replies and buffers one pending frame.

Parameters:
TX_GAP_CYCLES, 9000, minimum clk_25m cycles between EnTxData pulses (>= 4-byte serial time at 25 MHz/115200).
HDR_BYTE, 8'hAA, required DataRX_1 value.
RSP_BYTE, 8'h55, DataTX_1 value of every reply.

Ports:
clk_25m  in  1  system clock, 25 MHz
rst  in  1  synchronous reset, active-high
RX_rdy  in  1  frame-received indication; acted on at 0->1 edge only
DataRX_1..DataRX_5  in  8 each  header, opcode, data hi, data lo, checksum
EnTxData  out  1  one-cycle pulse: launch 4-byte reply
DataTX_1..DataTX_4  out  8 each  reply bytes, stable from pulse until next pulse
reg_wr  out  1  one-cycle write strobe
reg_rd  out  1  one-cycle read strobe
reg_addr  out  4  opcode[3:0]
reg_wdata  out  16  {DataRX_3, DataRX_4}
reg_rdata  in  16  read data, valid the cycle after reg_rd
start_pulse  out  1  one-cycle start strobe
busy  out  1  high whenever state != IDLE or pending frame held
ovf_cnt  out  8  dropped-frame count, saturates at 255

Behaviour:
- Reset: all outputs 0, DataTX_* = 0, gap counter 0, pending buffer empty, state IDLE, RX_rdy edge register 0.
- Opcode: [7:4] command, [3:0] address. 0x1 write, 0x2 read, 0x3 start. All other commands are illegal.
- Checksum: DataRX_5 == (DataRX_1+DataRX_2+DataRX_3+DataRX_4) mod 256.
- Status (priority order): header != HDR_BYTE -> E1; checksum bad -> E2; illegal command -> E3; else write 00, read 01, start 03.
- FSM:
  - IDLE: on RX_rdy edge (or pending valid), latch frame -> CHECK.
  - CHECK: compute status -> EXEC.
  - EXEC: valid write asserts reg_wr; valid read asserts reg_rd; valid start asserts start_pulse; errors assert nothing -> CAPT.
  - CAPT: build reply {RSP_BYTE, status, hi, lo}. hi/lo = reg_rdata for read, frame DataRX_3/4 for write, 0 for start/errors -> RESP.
  - RESP: wait until gap counter == 0; then load DataTX_*, pulse EnTxData, load gap counter with TX_GAP_CYCLES-1 -> IDLE.
- Gap counter: decrements to 0 each cycle, independent of state.
- Latency: RX_rdy edge sampled at cycle T, strobe at T+2, EnTxData at T+4 if gap already expired.
- RX_rdy edge while state != IDLE: frame stored in pending buffer if empty. If buffer is full, frame is dropped and ovf_cnt increments.
- Pending frame is taken in IDLE with priority over a simultaneous new edge. The new edge then refills the buffer.
- Reset mid-operation: any strobe in flight is suppressed the cycle after rst.

Optional Feature:
Macro CMD_CHECKSUM_EN.
- Defined: checksum checked; E2 reported as above.
- Undefined: DataRX_5 ignored; E2 never produced; remaining behaviour identical.

Test Plan:
- Write: frame AA 12 34 56 46 -> reg_wr one cycle at T+2, reg_addr=2, reg_wdata=3456; EnTxData at T+4 with 55 00 34 56.
- Read: frame AA 23 00 00 CD, reg_rdata=BEEF -> reg_rd at T+2, reg_addr=3; reply 55 01 BE EF.
- Errors: AA 12 34 56 47 -> 55 E2 00 00, no strobe. 00 12 34 56 9C -> 55 E1 00 00. AA 50 00 00 FA -> 55 E3 00 00. With macro undefined, first frame -> 55 00 34 56.
- Gap/pending: two valid frames 100 cycles apart -> second EnTxData exactly TX_GAP_CYCLES cycles after first; busy high throughout.
- Overflow: three frames within the gap -> third dropped, ovf_cnt=1, exactly two replies. At 255, further drops hold ovf_cnt at 255.
- Reset: rst asserted in RESP while waiting on gap -> no EnTxData; all outputs 0 next cycle; fresh frame then replies at T+4.
